// File: rtl/io_bus_if.sv
// Data-bus port bundle between the processor's memory stage and the I/O slave.
// Reads are registered in the slave, so rdata/rhit belong to the cycle after re.
interface io_bus_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             rhit;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rhit
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rhit
  );
endinterface

// File: rtl/io_bus_controller.sv
// Memory-mapped I/O slave: HEX/LEDR/LEDG output registers, synchronised
// KEY/SW inputs, sticky key-press edge capture and a prescaled interval timer.
// Read data is registered so it lines up with synchronous data-memory reads.
module io_bus_controller #(
  parameter int               DBITS     = 32,
  parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000000,
  parameter int               HEX_BITS  = 16,
  parameter int               LEDR_BITS = 10,
  parameter int               LEDG_BITS = 8,
  parameter int               KEY_BITS  = 4,
  parameter int               SW_BITS   = 10,
  parameter int               PRESCALE  = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  io_bus_if.slave              bus,
  input  logic [KEY_BITS-1:0]  key_n,
  input  logic [SW_BITS-1:0]   sw,
  output logic [HEX_BITS-1:0]  hex,
  output logic [LEDR_BITS-1:0] ledr,
  output logic [LEDG_BITS-1:0] ledg,
  output logic                 irq
);

  localparam logic [DBITS-1:0] A_HEX   = BASE_ADDR + DBITS'(8'h00);
  localparam logic [DBITS-1:0] A_LEDR  = BASE_ADDR + DBITS'(8'h04);
  localparam logic [DBITS-1:0] A_LEDG  = BASE_ADDR + DBITS'(8'h08);
  localparam logic [DBITS-1:0] A_KDATA = BASE_ADDR + DBITS'(8'h10);
  localparam logic [DBITS-1:0] A_SDATA = BASE_ADDR + DBITS'(8'h14);
  localparam logic [DBITS-1:0] A_KEDGE = BASE_ADDR + DBITS'(8'h18);
  localparam logic [DBITS-1:0] A_TCNT  = BASE_ADDR + DBITS'(8'h20);
  localparam logic [DBITS-1:0] A_TLIM  = BASE_ADDR + DBITS'(8'h24);
  localparam logic [DBITS-1:0] A_TCTL  = BASE_ADDR + DBITS'(8'h28);

  // Prescaler width guarded so PRESCALE=1 still yields a legal 1-bit counter.
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  // Synchronisers hold the pressed (active-high) sense so reset means "released".
  logic [KEY_BITS-1:0] key_s1, key_s2, key_prev;
  logic [SW_BITS-1:0]  sw_s1, sw_s2;
  logic [KEY_BITS-1:0] kedge;
  logic [KEY_BITS-1:0] key_rise;
  logic [KEY_BITS-1:0] kedge_clr;

  logic [DBITS-1:0] tcnt;
  logic [DBITS-1:0] tlim;
  logic [PW-1:0]    pre;
  logic             en, ready, ovf;
  logic             tick, wrap;

  logic             wr_hex, wr_ledr, wr_ledg, wr_kedge, wr_tcnt, wr_tlim, wr_tctl;
  logic             rd_hit;
  logic [DBITS-1:0] rd_val;

  assign wr_hex   = bus.we && (bus.addr == A_HEX);
  assign wr_ledr  = bus.we && (bus.addr == A_LEDR);
  assign wr_ledg  = bus.we && (bus.addr == A_LEDG);
  assign wr_kedge = bus.we && (bus.addr == A_KEDGE);
  assign wr_tcnt  = bus.we && (bus.addr == A_TCNT);
  assign wr_tlim  = bus.we && (bus.addr == A_TLIM);
  assign wr_tctl  = bus.we && (bus.addr == A_TCTL);

  assign key_rise  = key_s2 & ~key_prev;
  assign kedge_clr = wr_kedge ? bus.wdata[KEY_BITS-1:0] : '0;

  // A tick is the last prescaler count; wrap is a tick that hits the limit.
  assign tick = en && (pre == PRE_LAST);
  assign wrap = tick && (tlim != '0) && (tcnt == tlim - DBITS'(1));

  assign irq = ready | (|kedge);

  // Two-flop input synchronisers plus the delayed key copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      key_s1   <= ~key_n;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
    end
  end

  // Board output registers, loaded from the low bits of the store data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex  <= '0;
      ledr <= '0;
      ledg <= '0;
    end else begin
      if (wr_hex)  hex  <= bus.wdata[HEX_BITS-1:0];
      if (wr_ledr) ledr <= bus.wdata[LEDR_BITS-1:0];
      if (wr_ledg) ledg <= bus.wdata[LEDG_BITS-1:0];
    end
  end

  // Sticky key-press capture; a new press outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) kedge <= '0;
    else        kedge <= (kedge & ~kedge_clr) | key_rise;
  end

  // Interval timer: prescaler, counter, limit and control/status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre   <= '0;
      tcnt  <= '0;
      tlim  <= '0;
      en    <= 1'b0;
      ready <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_tcnt || wr_tlim) pre <= '0;
      else if (tick)          pre <= '0;
      else if (en)            pre <= pre + PW'(1);

      if (wr_tcnt)   tcnt <= bus.wdata;
      else if (wrap) tcnt <= '0;
      else if (tick) tcnt <= tcnt + DBITS'(1);

      if (wr_tlim) tlim <= bus.wdata;
      if (wr_tctl) en   <= bus.wdata[2];

      if (wrap && ready)               ovf <= 1'b1;
      else if (wr_tctl && !bus.wdata[1]) ovf <= 1'b0;

      if (wrap)                        ready <= 1'b1;
      else if (wr_tctl && !bus.wdata[0]) ready <= 1'b0;
    end
  end

  // Read decode from current (pre-write) register values, zero-extended.
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    if (bus.addr == A_HEX)        rd_val = DBITS'(hex);
    else if (bus.addr == A_LEDR)  rd_val = DBITS'(ledr);
    else if (bus.addr == A_LEDG)  rd_val = DBITS'(ledg);
    else if (bus.addr == A_KDATA) rd_val = DBITS'(key_s2);
    else if (bus.addr == A_SDATA) rd_val = DBITS'(sw_s2);
    else if (bus.addr == A_KEDGE) rd_val = DBITS'(kedge);
    else if (bus.addr == A_TCNT)  rd_val = tcnt;
    else if (bus.addr == A_TLIM)  rd_val = tlim;
    else if (bus.addr == A_TCTL)  rd_val = DBITS'({en, ovf, ready});
    else                          rd_hit = 1'b0;
  end

  // Registered read port; holds its value between loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata <= '0;
      bus.rhit  <= 1'b0;
    end else if (bus.re) begin
      bus.rdata <= rd_val;
      bus.rhit  <= rd_hit;
    end
  end

endmodule

// File: tb/tb_io_bus_controller.sv
// Bench for io_bus_controller: directed scenarios with literal expectations,
// then randomized bus/key/switch traffic compared every cycle to a register-level model.
module tb_io_bus_controller;
  localparam int          P    = 4;
  localparam logic [31:0] BASE = 32'hF0000000;
  localparam logic [31:0] HEXA = BASE + 32'h00, LEDRA = BASE + 32'h04, LEDGA = BASE + 32'h08;
  localparam logic [31:0] KDA  = BASE + 32'h10, SDA = BASE + 32'h14, KEA = BASE + 32'h18;
  localparam logic [31:0] TCNA = BASE + 32'h20, TLIA = BASE + 32'h24, TCTA = BASE + 32'h28;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [9:0] sw = '0;
  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic        irq;

  io_bus_if #(.DBITS(32)) bus ();

  io_bus_controller #(
    .DBITS(32), .BASE_ADDR(BASE), .HEX_BITS(16), .LEDR_BITS(10), .LEDG_BITS(8),
    .KEY_BITS(4), .SW_BITS(10), .PRESCALE(P)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .key_n(key_n), .sw(sw),
    .hex(hex), .ledr(ledr), .ledg(ledg), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [15:0] m_hex;  logic [9:0] m_ledr; logic [7:0] m_ledg;
  logic [31:0] m_rdata; logic m_rhit;
  logic [3:0]  pk [3];   // pressed history: [0]=newest sample
  logic [9:0]  ps [3];
  logic [3:0]  m_kedge;
  logic [31:0] m_tcnt, m_tlim;
  int          m_phase;
  logic        m_en, m_ready, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mread(input logic [31:0] a, output logic h, output logic [31:0] v);
    h = 1'b1;
    case (a)
      HEXA:    v = {16'd0, m_hex};
      LEDRA:   v = {22'd0, m_ledr};
      LEDGA:   v = {24'd0, m_ledg};
      KDA:     v = {28'd0, pk[1]};
      SDA:     v = {22'd0, ps[1]};
      KEA:     v = {28'd0, m_kedge};
      TCNA:    v = m_tcnt;
      TLIA:    v = m_tlim;
      TCTA:    v = {29'd0, m_en, m_ovf, m_ready};
      default: begin h = 1'b0; v = 32'd0; end
    endcase
  endtask

  task automatic model_update();
    logic h, tk, wrap;
    logic [31:0] v;
    logic [3:0] rise, kclr;
    if (!reset) begin
      m_hex = '0; m_ledr = '0; m_ledg = '0; m_rdata = '0; m_rhit = 1'b0;
      for (int i = 0; i < 3; i++) begin pk[i] = '0; ps[i] = '0; end
      m_kedge = '0; m_tcnt = '0; m_tlim = '0; m_phase = 0;
      m_en = 1'b0; m_ready = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (bus.re) begin
      mread(bus.addr, h, v);
      m_rhit = h; m_rdata = v;
    end
    rise = pk[1] & ~pk[2];
    pk[2] = pk[1]; pk[1] = pk[0]; pk[0] = ~key_n;
    ps[2] = ps[1]; ps[1] = ps[0]; ps[0] = sw;
    kclr = (bus.we && bus.addr == KEA) ? bus.wdata[3:0] : 4'd0;
    m_kedge = (m_kedge & ~kclr) | rise;
    tk = m_en && (m_phase == P - 1);
    wrap = tk && (m_tlim != 0) && (m_tcnt == m_tlim - 32'd1);
    if (bus.we && (bus.addr == TCNA || bus.addr == TLIA)) m_phase = 0;
    else if (m_en) m_phase = (m_phase + 1) % P;
    if (bus.we && bus.addr == TCNA) m_tcnt = bus.wdata;
    else if (wrap) m_tcnt = 32'd0;
    else if (tk) m_tcnt = m_tcnt + 32'd1;
    if (wrap && m_ready) m_ovf = 1'b1;
    else if (bus.we && bus.addr == TCTA && !bus.wdata[1]) m_ovf = 1'b0;
    if (wrap) m_ready = 1'b1;
    else if (bus.we && bus.addr == TCTA && !bus.wdata[0]) m_ready = 1'b0;
    if (bus.we && bus.addr == TCTA) m_en = bus.wdata[2];
    if (bus.we && bus.addr == TLIA) m_tlim = bus.wdata;
    if (bus.we && bus.addr == HEXA) m_hex = bus.wdata[15:0];
    if (bus.we && bus.addr == LEDRA) m_ledr = bus.wdata[9:0];
    if (bus.we && bus.addr == LEDGA) m_ledg = bus.wdata[7:0];
  endtask

  task automatic compare_all();
    check("hex", {16'd0, hex}, {16'd0, m_hex});
    check("ledr", {22'd0, ledr}, {22'd0, m_ledr});
    check("ledg", {24'd0, ledg}, {24'd0, m_ledg});
    check("rdata", bus.rdata, m_rdata);
    check("rhit", {31'd0, bus.rhit}, {31'd0, m_rhit});
    check("irq", {31'd0, irq}, {31'd0, m_ready | (|m_kedge)});
  endtask

  // One clock: model advances on the edge, DUT compared just after it.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus.addr = a; bus.re = 1'b1;
    step();
    bus.re = 1'b0;
  endtask

  logic [31:0] addrs [13];

  initial begin
    addrs = '{HEXA, LEDRA, LEDGA, KDA, SDA, KEA, TCNA, TLIA, TCTA,
              BASE + 32'h3C, BASE + 32'h0C, 32'h0000_0000, BASE + 32'h100};
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    repeat (3) step();
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    repeat (2) step();

    // Output registers and read path
    bus_write(HEXA, 32'h0000BEEF);
    bus_write(LEDRA, 32'h3FF);
    check("lit_hex", {16'd0, hex}, 32'hBEEF);
    check("lit_ledr", {22'd0, ledr}, 32'h3FF);
    bus_read(HEXA);
    check("lit_rd_hex", bus.rdata, 32'h0000BEEF);
    check("lit_rhit1", {31'd0, bus.rhit}, 32'd1);
    bus_read(BASE + 32'h3C);
    check("lit_rd_unmapped", bus.rdata, 32'd0);
    check("lit_rhit0", {31'd0, bus.rhit}, 32'd0);

    // Key edge capture
    key_n = 4'hE;
    repeat (2) step();
    check("lit_irq_before_edge", {31'd0, irq}, 32'd0);
    step();
    check("lit_irq_edge", {31'd0, irq}, 32'd1);
    bus_read(KDA);
    check("lit_kdata", bus.rdata, 32'd1);
    bus_write(KEA, 32'd1);
    check("lit_kedge_clr_irq", {31'd0, irq}, 32'd0);
    key_n = 4'hF;
    repeat (4) step();
    key_n = 4'hE;
    repeat (2) step();
    bus_write(KEA, 32'd1);
    check("lit_set_beats_clr", {31'd0, irq}, 32'd1);
    bus_read(KEA);
    check("lit_kedge_read", bus.rdata, 32'd1);
    bus_write(KEA, 32'hF);
    key_n = 4'hF;
    repeat (4) step();

    // Timer period and overflow
    bus_write(TLIA, 32'd3);
    bus_write(TCTA, 32'h4);
    repeat (11) step();
    check("lit_ready_not_yet", {31'd0, irq}, 32'd0);
    step();
    check("lit_ready_at_12", {31'd0, irq}, 32'd1);
    bus_read(TCNA);
    check("lit_tcnt_zero", bus.rdata, 32'd0);
    repeat (12) step();
    bus_read(TCTA);
    check("lit_tctl_ovf", bus.rdata, 32'h7);
    bus_write(TCTA, 32'h4);
    bus_read(TCTA);
    check("lit_tctl_cleared", bus.rdata, 32'h4);

    // Free-running wrap and TCNT write against a tick
    bus_write(TCTA, 32'h0);
    bus_write(TLIA, 32'h0);
    bus_write(TCNA, 32'hFFFF_FFFF);
    bus_write(TCTA, 32'h4);
    repeat (4) step();
    bus_read(TCNA);
    check("lit_tcnt_wrap", bus.rdata, 32'd0);
    bus_read(TCTA);
    check("lit_free_no_ready", bus.rdata, 32'h4);
    step();
    bus_write(TCNA, 32'h55);
    bus_read(TCNA);
    check("lit_tcnt_write_wins", bus.rdata, 32'h55);

    // Simultaneous load and store
    bus_write(LEDGA, 32'h12);
    bus.addr = LEDGA; bus.wdata = 32'h34; bus.we = 1'b1; bus.re = 1'b1;
    step();
    bus.we = 1'b0; bus.re = 1'b0;
    check("lit_rw_old", bus.rdata, 32'h12);
    check("lit_rw_new", {24'd0, ledg}, 32'h34);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int op, idx;
      logic [31:0] d;
      if ($urandom_range(0, 7) == 0) key_n = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
      op = $urandom_range(0, 3);
      idx = $urandom_range(0, 12);
      d = $urandom;
      if (addrs[idx] == TLIA) d = $urandom_range(0, 4);
      if (addrs[idx] == TCNA) d = $urandom_range(0, 6);
      if (addrs[idx] == TCTA) d = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'h4 : 32'h0);
      bus.addr = addrs[idx];
      bus.wdata = d;
      bus.we = (op == 1) || (op == 3);
      bus.re = (op == 2) || (op == 3);
      step();
    end
    bus.we = 1'b0; bus.re = 1'b0;

    // Asynchronous reset mid-run with the timer enabled
    bus_write(HEXA, 32'h1234);
    bus_write(TLIA, 32'd2);
    bus_write(TCTA, 32'h4);
    repeat (10) step();
    bus_read(HEXA);
    #2 reset = 1'b0;
    #1;
    check("lit_rst_hex", {16'd0, hex}, 32'd0);
    check("lit_rst_ledr", {22'd0, ledr}, 32'd0);
    check("lit_rst_ledg", {24'd0, ledg}, 32'd0);
    check("lit_rst_irq", {31'd0, irq}, 32'd0);
    check("lit_rst_rdata", bus.rdata, 32'd0);
    check("lit_rst_rhit", {31'd0, bus.rhit}, 32'd0);
    step();
    reset = 1'b1;
    repeat (6) step();
    bus_read(TCNA);
    check("lit_rst_tcnt", bus.rdata, 32'd0);
    bus_read(TCTA);
    check("lit_rst_tctl", bus.rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_bus_controller.md
# io_bus_controller

Parametrised memory-mapped I/O controller for the single-cycle/pipelined processor: one slave on the data bus that owns the board outputs (HEX, LEDR, LEDG), the synchronised inputs (KEY, SW), a sticky key-edge capture register and a programmable interval timer. It replaces the per-device output registers and the combinational KEY/SW read mux. Read data is registered, so it aligns with the write-back stage exactly as synchronous data-memory reads do.

## Interface
- DBITS, 32, bus data/address width
- BASE_ADDR, 32'hF0000000, base of the I/O window; offsets below are byte offsets from it
- HEX_BITS, 16, HEX output register width (4 bits per digit)
- LEDR_BITS, 10, red LED register width
- LEDG_BITS, 8, green LED register width
- KEY_BITS, 4, number of push-buttons
- SW_BITS, 10, number of switches
- PRESCALE, 50000, clk cycles per timer tick (>=1)
- clk  in  1  system clock; the single clock for all state
- reset  in  1  asynchronous, active-low reset
- addr  in  DBITS  byte address from ALU
- wdata  in  DBITS  store data
- we  in  1  store strobe; sampled at posedge clk
- re  in  1  load strobe; sampled at posedge clk
- rdata  out  DBITS  registered read data, valid the cycle after re
- rhit  out  1  registered; 1 when the rdata cycle corresponds to a mapped address
- key_n  in  KEY_BITS  raw buttons, 0 = pressed, asynchronous
- sw  in  SW_BITS  raw switches, asynchronous
- hex  out  HEX_BITS  HEX register
- ledr  out  LEDR_BITS  LEDR register
- ledg  out  LEDG_BITS  LEDG register
- irq  out  1  timer ready OR any key-edge bit (level)

## Operation
- Register map (offset, access): 0x00 HEX rw; 0x04 LEDR rw; 0x08 LEDG rw; 0x10 KDATA ro (pressed = 1); 0x14 SDATA ro; 0x18 KEDGE rw1c; 0x20 TCNT rw; 0x24 TLIM rw; 0x28 TCTL rw.
- Decode: full DBITS compare of addr against BASE_ADDR+offset; unmapped addresses ignore writes, read 0 with rhit=0. Reads zero-extend narrow registers; writes take the low bits of wdata.
- Inputs: two-flop synchroniser per bit; KDATA = ~synchronised key_n.
- KEDGE: bit i sets on a 0->1 transition of KDATA[i]; write clears bits where wdata=1. Same-cycle set and clear: set wins.
- Timer: prescaler counts 0..PRESCALE-1 continuously while TCTL.en=1, emitting a one-cycle tick at PRESCALE-1. On tick: if TLIM!=0 and TCNT==TLIM-1, TCNT<=0 and TCTL.ready<=1 (if ready already 1, TCTL.ovf<=1); else TCNT<=TCNT+1 (wraps modulo 2^DBITS). TLIM=0 = free-running, never sets ready.
- TCTL bits: [0] ready, [1] ovf, [2] en. Write: en<=wdata[2]; writing 0 to bit0/bit1 clears that flag, 1 leaves it. Hardware set beats software clear in the same cycle.
- TCNT write takes priority over a same-cycle tick; writing TCNT or TLIM resets the prescaler to 0. Clearing en freezes TCNT and the prescaler.
- we and re in the same cycle: write performed, rdata returns the pre-write value.
- irq = TCTL.ready | (|KEDGE).

## Timing
- Reset (asserted low, any time, asynchronous): hex, ledr, ledg, rdata, rhit, KEDGE, TCNT, TLIM, TCTL, prescaler, synchronisers all 0; irq 0. Deassertion mid-operation restarts from these values; no partial write survives.
- Writes: register updates at the posedge where we=1; output pins change in the same cycle.
- Reads: 1-cycle latency; rdata/rhit update at the posedge sampling re and hold until the next re cycle.
- Input latency: key_n/sw change visible in KDATA/SDATA after 2 posedges; KEDGE bit sets on the 3rd.
- Timer period with TLIM=N: ready sets every N*PRESCALE cycles after en.

## Test plan
- Reset: drive reset=0 mid-run with timer enabled -> all outputs 0, TCNT 0, irq 0 immediately, no clk edge needed.
- Output regs: store 0x0000BEEF to 0xF0000000, 0x3FF to 0xF0000004 -> hex=16'hBEEF, ledr=10'h3FF next cycle; load 0xF0000000 -> rdata=0x0000BEEF, rhit=1 one cycle after re; load 0xF000003C -> rdata 0, rhit 0.
- Key edge: key_n 4'hF->4'hE -> KDATA=1 after 2 cycles, KEDGE=1 and irq=1 after 3; write 1 to 0xF0000018 -> KEDGE 0; release/press same cycle as clear -> KEDGE stays 1.
- Timer: PRESCALE=4, TLIM=3, TCTL=0x4 -> ready at cycle 12, TCNT 0; leave ready set for another 12 cycles -> ovf=1; write TCTL=0x4 -> ready and ovf cleared, en kept.
- Timer corner: TLIM=0, TCNT=0xFFFFFFFF, en -> TCNT wraps to 0 after one tick, ready stays 0; TCNT write on a tick cycle -> written value wins.
- Simultaneous we/re to LEDG old 0x12, new 0x34 -> rdata 0x12, ledg 0x34.
